// File: rtl/ppe_dispatch_sched_pkg.sv
// Packet format and opcodes shared by the PPE, the combining PE and this dispatcher.
package ppe_dispatch_sched_pkg;

  localparam int PKT_W      = 30;
  localparam int ADDR_START = 29;
  localparam int ADDR_END   = 26;
  localparam int OPCODE     = 25;
  localparam int DATA_START = 24;
  localparam int DATA_END   = 0;
  localparam int DATA_W     = DATA_START - DATA_END + 1;
  localparam int DEST_W     = ADDR_START - ADDR_END + 1;

  typedef enum logic {
    WEIGHT = 1'b0,
    INPUT  = 1'b1
  } opcode_e;

  typedef logic [PKT_W-1:0] pkt_t;

  function automatic pkt_t make_pkt(input logic [DEST_W-1:0] dest, input opcode_e op,
                                    input logic [DATA_W-1:0] data);
    pkt_t p;
    p = '0;
    p[ADDR_START:ADDR_END] = dest;
    p[OPCODE]              = op;
    p[DATA_START:DATA_END] = data;
    return p;
  endfunction

endpackage

// File: rtl/ppe_dispatch_sched_credit.sv
// Up/down credit counter tracking outputs in flight; err latches a completion seen with nothing outstanding.
module ppe_credit_ctr #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CR_W            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CR_W-1:0] credits_o,
  output logic            err_o
);

  localparam logic [CR_W-1:0] CR_MAX = CR_W'(MAX_OUTSTANDING);

  logic [CR_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (dec_i && !inc_i && (cnt_q == '0));
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != CR_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credits_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: rtl/ppe_dispatch_sched.sv
// Streams kernel rows as WEIGHT packets, then per-output ifmap windows as INPUT packets,
// throttled by credits returned through sum_done.
module ppe_dispatch_sched
  import ppe_dispatch_sched_pkg::*;
#(
  parameter int FILTER_SIZE     = 5,
  parameter int IFMAP_SIZE      = 25,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      start_i,
  output logic                                      pkt_valid_o,
  input  logic                                      pkt_ready_i,
  output logic [29:0]                               pkt_data_o,
  output logic                                      w_rd_en_o,
  output logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0] w_addr_o,
  input  logic [7:0]                                w_rdata_i,
  output logic                                      if_rd_en_o,
  output logic [$clog2(IFMAP_SIZE)-1:0]             if_addr_o,
  input  logic [IFMAP_SIZE-1:0]                     if_rdata_i,
  input  logic                                      sum_done_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      err_o
);

  localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int WA_W = $clog2(FILTER_SIZE * FILTER_SIZE);
  localparam int IA_W = $clog2(IFMAP_SIZE);
  localparam int CR_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int R_W  = $clog2(FILTER_SIZE + 1);
  localparam int O_W  = $clog2(OUTPUT_DIM + 1);

  localparam logic [R_W-1:0]  R_LAST = R_W'(FILTER_SIZE - 1);
  localparam logic [O_W-1:0]  O_LAST = O_W'(OUTPUT_DIM - 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(MAX_OUTSTANDING);

  typedef enum logic [3:0] {
    IDLE, W_RD_LO, W_RD_HI, W_SEND, I_RD, I_CAP, I_SEND, DRAIN, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [R_W-1:0]  r_q, r_d;
  logic [R_W-1:0]  c_q, c_d;
  logic [O_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [7:0]      lo_q, lo_d;
  pkt_t            pkt_q, pkt_d;
  logic            pkt_valid_q, pkt_valid_d;

  logic            cr_clr, cr_inc;
  logic [CR_W-1:0] credits;
  logic            xfer;
  logic            has_hi;
  logic [7:0]      hi_byte;
  logic [IFMAP_SIZE-1:0]  row_sh;
  logic [FILTER_SIZE-1:0] window;

  assign xfer    = pkt_valid_q && pkt_ready_i;
  assign has_hi  = (int'(c_q) + 1) < FILTER_SIZE;
  assign hi_byte = has_hi ? w_rdata_i : 8'd0;
  assign row_sh  = if_rdata_i >> ox_q;
  assign window  = row_sh[FILTER_SIZE-1:0];

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    lo_d        = lo_q;
    pkt_d       = pkt_q;
    pkt_valid_d = pkt_valid_q;
    cr_clr      = 1'b0;
    cr_inc      = 1'b0;
    w_rd_en_o   = 1'b0;
    w_addr_o    = '0;
    if_rd_en_o  = 1'b0;
    if_addr_o   = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          r_d     = '0;
          c_d     = '0;
          ox_d    = '0;
          oy_d    = '0;
          cr_clr  = 1'b1;
          state_d = W_RD_LO;
        end
      end
      W_RD_LO: begin
        w_rd_en_o = 1'b1;
        w_addr_o  = WA_W'(int'(r_q) * FILTER_SIZE + int'(c_q));
        state_d   = W_RD_HI;
      end
      W_RD_HI: begin
        lo_d = w_rdata_i;
        if (has_hi) begin
          w_rd_en_o = 1'b1;
          w_addr_o  = WA_W'(int'(r_q) * FILTER_SIZE + int'(c_q) + 1);
        end
        state_d = W_SEND;
      end
      W_SEND: begin
        // First cycle here is the one where the high byte read returns.
        if (!pkt_valid_q) begin
          pkt_d       = make_pkt(DEST_W'(r_q), WEIGHT, DATA_W'({hi_byte, lo_q}));
          pkt_valid_d = 1'b1;
        end else if (pkt_ready_i) begin
          pkt_valid_d = 1'b0;
          state_d     = W_RD_LO;
          if ((int'(c_q) + 2) >= FILTER_SIZE) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = I_RD;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + R_W'(2);
          end
        end
      end
      I_RD: begin
        if (!((r_q == '0) && (credits == CR_MAX))) begin
          if_rd_en_o = 1'b1;
          if_addr_o  = IA_W'(int'(oy_q) + int'(r_q));
          state_d    = I_CAP;
        end
      end
      I_CAP: begin
        pkt_d       = make_pkt(DEST_W'(r_q), INPUT, DATA_W'(window));
        pkt_valid_d = 1'b1;
        state_d     = I_SEND;
      end
      I_SEND: begin
        if (xfer) begin
          pkt_valid_d = 1'b0;
          state_d     = I_RD;
          if (r_q == R_LAST) begin
            cr_inc = 1'b1;
            r_d    = '0;
            if (ox_q == O_LAST) begin
              ox_d = '0;
              if (oy_q == O_LAST) begin
                oy_d    = '0;
                state_d = DRAIN;
              end else begin
                oy_d = oy_q + 1'b1;
              end
            end else begin
              ox_d = ox_q + 1'b1;
            end
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (credits == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      lo_q        <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      lo_q        <= lo_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  ppe_credit_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CR_W           (CR_W)
  ) u_credit (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (cr_clr),
    .inc_i    (cr_inc),
    .dec_i    (sum_done_i),
    .credits_o(credits),
    .err_o    (err_o)
  );

  assign pkt_valid_o = pkt_valid_q;
  assign pkt_data_o  = pkt_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_ppe_dispatch_sched.sv
// Scoreboard bench: expected packet stream built from the layer rules, a combining-PE model
// returns sum_done, and a monitor checks every transfer plus hold/valid-drop behaviour.
module tb_ppe_dispatch_sched;
  import ppe_dispatch_sched_pkg::*;

  localparam int F    = 5;
  localparam int IFM  = 25;
  localparam int MAXO = 2;
  localparam int OD   = IFM - F + 1;
  localparam int WA_W = $clog2(F * F);
  localparam int IA_W = $clog2(IFM);
  localparam int N_W  = F * ((F + 1) / 2);
  localparam int N_IN = OD * OD * F;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            pkt_ready = 1'b1;
  logic            sum_man = 1'b0;
  logic            sum_auto = 1'b0;
  logic            sum_done;
  logic [7:0]      w_rdata = '0;
  logic [IFM-1:0]  if_rdata = '0;
  logic            pkt_valid, w_rd_en, if_rd_en, busy, done, err;
  logic [29:0]     pkt_data;
  logic [WA_W-1:0] w_addr;
  logic [IA_W-1:0] if_addr;

  logic [7:0]      wmem  [F*F];
  logic [IFM-1:0]  ifmem [IFM];
  logic [29:0]     exp_q [$];

  int  compared = 0, mismatched = 0;
  int  w_cnt = 0, in_cnt = 0, sd_push = 0, sd_pop = 0;
  bit  sum_en = 1'b0, rand_ready = 1'b0;

  assign sum_done = sum_man | sum_auto;

  ppe_dispatch_sched #(.FILTER_SIZE(F), .IFMAP_SIZE(IFM), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .pkt_valid_o(pkt_valid), .pkt_ready_i(pkt_ready), .pkt_data_o(pkt_data),
    .w_rd_en_o(w_rd_en), .w_addr_o(w_addr), .w_rdata_i(w_rdata),
    .if_rd_en_o(if_rd_en), .if_addr_o(if_addr), .if_rdata_i(if_rdata),
    .sum_done_i(sum_done), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en)  w_rdata  <= wmem[w_addr];
    if (if_rd_en) if_rdata <= ifmem[if_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_expected();
    logic [7:0]     lo, hi;
    logic [IFM-1:0] row;
    logic [24:0]    d;
    for (int i = 0; i < F*F; i++) wmem[i] = 8'($urandom);
    for (int i = 0; i < IFM; i++) ifmem[i] = IFM'($urandom);
    exp_q.delete();
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F; c += 2) begin
        lo = wmem[r*F + c];
        hi = (c + 1 < F) ? wmem[r*F + c + 1] : 8'd0;
        exp_q.push_back({4'(r), 1'b0, 9'b0, hi, lo});
      end
    for (int oy = 0; oy < OD; oy++)
      for (int ox = 0; ox < OD; ox++)
        for (int r = 0; r < F; r++) begin
          row = ifmem[oy + r] >> ox;
          d = '0;
          d[F-1:0] = row[F-1:0];
          exp_q.push_back({4'(r), 1'b1, d});
        end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready seen here.
  logic [29:0] hold_data;
  bit          holding = 1'b0, prev_xfer = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      holding   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (prev_xfer) check("valid_drop_after_xfer", {31'b0, pkt_valid}, 32'd0);
      if (pkt_valid && holding) check("data_hold_stable", {2'b0, pkt_data}, {2'b0, hold_data});
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL pkt_unexpected: got %0h expected none", pkt_data);
        end else begin
          check("pkt", {2'b0, pkt_data}, {2'b0, exp_q.pop_front()});
        end
        if (pkt_data[OPCODE]) begin
          in_cnt++;
          if (in_cnt % F == 0) sd_push++;
        end else begin
          w_cnt++;
        end
        holding   = 1'b0;
        prev_xfer = 1'b1;
      end else begin
        prev_xfer = 1'b0;
        holding   = pkt_valid;
        hold_data = pkt_data;
      end
    end
  end

  // Combining-PE model: one sum_done per completed output after a random delay.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      sd_pop   = sd_push;
      sum_auto = 1'b0;
    end else if (sum_en && sd_pop < sd_push && $urandom_range(0, 2) == 0) begin
      sum_auto = 1'b1;
      sd_pop++;
    end else begin
      sum_auto = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    pkt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic run_start();
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 check("first_valid_early", {31'b0, pkt_valid}, 32'd0);
    @(posedge clk);
    #1 check("first_valid_at_3", {31'b0, pkt_valid}, 32'd1);
  endtask

  task automatic wait_in(input int base, input int n, input int budget);
    int k = 0;
    while ((in_cnt - base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if ((in_cnt - base) < n) begin
      mismatched++;
      $display("FAIL timeout_inputs: got %0d packets required %0d", in_cnt - base, n);
    end
  endtask

  task automatic wait_valid_xfer(input int base, input int n_before, input int budget);
    int k = 0;
    forever begin
      @(posedge clk);
      #2;
      k++;
      if (pkt_valid && pkt_ready && (in_cnt - base) == n_before) break;
      if (k >= budget) begin
        compared++;
        mismatched++;
        $display("FAIL timeout_xfer: got %0d packets required %0d", in_cnt - base, n_before);
        break;
      end
    end
  endtask

  task automatic pulse_sum();
    @(posedge clk); #1 sum_man = 1'b1;
    @(posedge clk); #1 sum_man = 1'b0;
  endtask

  task automatic full_run(input bit stalls);
    int base_i, base_w, k;
    sum_en     = 1'b1;
    rand_ready = stalls;
    base_i     = in_cnt;
    base_w     = w_cnt;
    run_start();
    k = 0;
    while (!done && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
    check("weight_pkts", w_cnt - base_w, N_W);
    check("input_pkts", in_cnt - base_i, N_IN);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    check("err_clean_run", {31'b0, err}, 32'd0);
    rand_ready = 1'b0;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pkt_valid", {31'b0, pkt_valid}, 32'd0);
    check("rst_pkt_data", {2'b0, pkt_data}, 32'd0);
    check("rst_w_rd_en", {31'b0, w_rd_en}, 32'd0);
    check("rst_if_rd_en", {31'b0, if_rd_en}, 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_if_addr", 32'(if_addr), 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Credit throttling with sum_done under manual control.
    sum_en = 1'b0;
    base   = in_cnt;
    run_start();
    wait_in(base, 10, 3000);
    repeat (100) @(negedge clk);
    check("throttle_at_10", in_cnt - base, 32'd10);
    check("throttle_valid_low", {31'b0, pkt_valid}, 32'd0);
    pulse_sum();
    repeat (100) @(negedge clk);
    check("one_credit_5_more", in_cnt - base, 32'd15);
    pulse_sum();
    wait_valid_xfer(base, 19, 300);
    sum_man = 1'b1;
    @(posedge clk); #1 sum_man = 1'b0;
    repeat (100) @(negedge clk);
    check("coincident_unchanged", in_cnt - base, 32'd25);
    check("err_before_extra", {31'b0, err}, 32'd0);

    // Reset while a packet is being offered.
    pulse_sum();
    begin
      int k = 0;
      while (!pkt_valid && k < 100) begin
        @(posedge clk);
        #2;
        k++;
      end
    end
    check("valid_before_reset", {31'b0, pkt_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_valid", {31'b0, pkt_valid}, 32'd0);
    check("reset_mid_busy", {31'b0, busy}, 32'd0);
    check("reset_mid_data", {2'b0, pkt_data}, 32'd0);
    reset = 1'b0;
    exp_q.delete();

    // Completion with zero credits outstanding.
    pulse_sum();
    check("err_set", {31'b0, err}, 32'd1);
    repeat (5) @(posedge clk);
    #1 check("err_sticky", {31'b0, err}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("err_cleared", {31'b0, err}, 32'd0);

    full_run(1'b1);
    full_run(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

endmodule

// File: doc/ppe_dispatch_sched.md
# ppe_dispatch_sched

Clocked scheduler that sequences the partial-PE array of one convolution layer. It first streams each kernel row into its partial PE (PPE) as WEIGHT packets. It then walks every output position and sends each PPE its FILTER_SIZE-bit ifmap window as INPUT packets. A credit counter throttles dispatch against partial-sum completions from the combining PE. The block sits between the weight/ifmap memories and the NoC injection port feeding PPE addresses 0..FILTER_SIZE-1.

## Interface
- FILTER_SIZE, 5, kernel edge; also the number of PPEs, addressed 0..FILTER_SIZE-1
- IFMAP_SIZE, 25, ifmap edge; OUTPUT_DIM = IFMAP_SIZE-FILTER_SIZE+1
- MAX_OUTSTANDING, 2, outputs allowed in flight before waiting on sum_done
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, sampled only in IDLE
- pkt_valid  out  1  packet on pkt_data is valid
- pkt_ready  in  1  NoC accepts; a transfer occurs when valid&ready at an edge
- pkt_data  out  30  [29:26] dest PPE, [25] opcode (WEIGHT=0, INPUT=1), [24:0] data
- w_rd_en  out  1  weight memory read strobe
- w_addr  out  $clog2(FILTER_SIZE*FILTER_SIZE)  row-major r*FILTER_SIZE+c
- w_rdata  in  8  signed weight, valid the cycle after w_rd_en
- if_rd_en  out  1  ifmap row read strobe
- if_addr  out  $clog2(IFMAP_SIZE)  ifmap row index
- if_rdata  in  IFMAP_SIZE  1-bit spikes of one row, bit j = column j, valid the cycle after if_rd_en
- sum_done  in  1  one-cycle pulse per completed output from the combining PE
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at layer completion
- err  out  1  sticky; set on sum_done with zero credits outstanding; cleared only by reset

## Operation
- States: IDLE, W_RD_LO, W_RD_HI, W_SEND, I_RD, I_CAP, I_SEND, DRAIN, DONE.
- IDLE → W_RD_LO on start. Clear counters r, c, ox, oy, and credits.
- Weight phase, for each PPE r:
  - W_RD_LO reads (r,c).
  - W_RD_HI captures the low byte. It reads (r,c+1) if c+1<FILTER_SIZE; otherwise the high byte is 0 and no read is issued.
  - W_SEND drives dest=r, opcode 0, data={9'b0, hi, lo}.
  - After the transfer, c+=2. If c≥FILTER_SIZE: c=0, r++.
  - After the last PPE: r=0, go to I_RD.
  - Total weight packets = FILTER_SIZE*ceil(FILTER_SIZE/2) (15 at default).
- Input phase, for each output (oy,ox), oy outer, ox inner; for each r:
  - I_RD: when r==0, wait here while credits==MAX_OUTSTANDING. Otherwise issue a read of row oy+r.
  - I_CAP registers if_rdata[ox +: FILTER_SIZE].
  - I_SEND drives dest=r, opcode 1, data[FILTER_SIZE-1:0]=window (bit 0 = column ox), upper bits 0.
  - After the transfer at r==FILTER_SIZE-1: credits++, r=0, advance ox. At ox wrap, ox=0 and oy++.
  - After the final output (oy=ox=OUTPUT_DIM-1): go to DRAIN.
- DRAIN: wait for credits==0, then go to DONE. DONE pulses done and returns to IDLE.
- Credits width is $clog2(MAX_OUTSTANDING+1).
- Credit updates:
  - sum_done alone: credits--.
  - Output completion alone: credits++.
  - Both in the same cycle: unchanged.
  - sum_done at credits==0 (and no simultaneous increment): credits stays 0 and err is set.
- start while busy is ignored.
- reset in any state forces IDLE next cycle and clears all counters. err is cleared; the in-flight packet is abandoned.

## Timing
- Reset values: pkt_valid=0, pkt_data=0, w_rd_en=0, if_rd_en=0, w_addr=0, if_addr=0, busy=0, done=0, err=0.
- pkt_data and pkt_valid are registered. Once valid rises, pkt_data is held stable until the transfer edge.
- pkt_valid falls the cycle after a transfer; there are no back-to-back transfers.
- The first weight packet is valid 3 cycles after the edge that samples start.
- Each weight packet costs at least 3 cycles with ready held high; each input packet costs at least 3 cycles.
- done rises exactly one cycle after DRAIN sees credits==0.
- Read strobes are single-cycle, with addresses valid in the same cycle.

## Structure
- Shared package (used by PPE and combining PE) holds:
  - packet field positions ADDR_START=29, ADDR_END=26, OPCODE=25, DATA_START=24, DATA_END=0;
  - opcode enum {WEIGHT=0, INPUT=1};
  - the 30-bit packet typedef.
- The state enum is local to this block.
- One natural sub-module, ppe_credit_ctr: up/down saturating credit counter with err flag.

## Test plan
- Reset then start, F=5, IFMAP=25, ready always 1 → 15 weight packets, first to PPE0 with data={hi=w(0,1), lo=w(0,0)}, third with hi=0. Then 2205 input packets, then done.
- IFMAP=7 (OUTPUT_DIM 3), ifmap row k = 7'b1010101<<k truncated → 45 input packets. Output (1,2) to PPE3 carries row 4 bits [6:2].
- sum_done withheld, MAX_OUTSTANDING=2 → exactly 10 input packets, then pkt_valid stays 0. One sum_done pulse → 5 more packets.
- Random pkt_ready stalls → pkt_data stable while valid&!ready; packet sequence identical to the no-stall run.
- sum_done coincident with the completion of output 3 → credits unchanged. An extra sum_done at credits 0 → err=1 and stays 1.
- reset asserted mid input phase → next cycle pkt_valid=0, busy=0. A new start replays from the first weight packet.
